key_event_decoder: RTL
======================

Name: key_event_decoder

Overview:
- Consumes the 3-bit active-low debounced key levels from the key debouncer and turns them into discrete single-cycle events: press, release, long-press and auto-repeat.
- Provides per-key pulse vectors plus one encoded event bus (key index + event type) for the menu/control FSMs downstream.
- Sits directly after the debouncer in the same clock domain.

Parameters:
- LONG_CYCLES, 25_000_000, held cycles from press to long-press event (0.5 s at 50 MHz); must be >= 2.
- REPEAT_CYCLES, 5_000_000, cycles between auto-repeat events after long-press; must be >= 2.
- REPEAT_EN, 1, 1 = auto-repeat enabled; 0 = no repeat events after long-press.
- CNT_W, 25, hold counter width; must hold max(LONG_CYCLES, REPEAT_CYCLES)-1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- key_value  input  3  debounced key levels, 0 = pressed, idle 3'b111
- press_pulse  output  3  one-cycle pulse per key on press
- release_pulse  output  3  one-cycle pulse per key on release
- long_pulse  output  3  one-cycle pulse per key on long-press threshold
- repeat_pulse  output  3  one-cycle pulse per key on each auto-repeat
- evt_valid  output  1  encoded event strobe, one cycle
- evt_key  output  2  key index 0..2 of encoded event
- evt_type  output  2  00 press, 01 release, 10 long, 11 repeat
- evt_drop  output  1  one-cycle pulse: at least one lower-priority event lost this cycle

Behaviour:
- One clock `clk`. Asynchronous active-low reset `rst_n`.
- Reset: all pulse outputs, evt_valid, evt_drop = 0; evt_key = 0; evt_type = 0; kv_d (previous-level register) = 3'b111; all key FSMs = IDLE; counters = 0.
- Edge detection per key i:
  - Press = kv_d[i]==1 and key_value[i]==0 at a clock edge.
  - Release = kv_d[i]==0 and key_value[i]==1.
  - kv_d <= key_value every cycle.
- Per-key FSM states and transitions:
  - IDLE: on press -> HELD; cnt <= 0; press_pulse[i] registered high for exactly the following cycle.
  - HELD: cnt increments each cycle.
    - When cnt == LONG_CYCLES-1 and the key is still pressed: long_pulse[i] goes high next cycle; cnt <= 0; state -> REPEAT if REPEAT_EN, else LATCHED.
    - Resulting timing: long_pulse rises exactly LONG_CYCLES cycles after press_pulse.
  - REPEAT: cnt increments. When cnt == REPEAT_CYCLES-1: repeat_pulse[i] next cycle; cnt <= 0. Consecutive repeat pulses are exactly REPEAT_CYCLES apart; the first comes REPEAT_CYCLES after long_pulse.
  - LATCHED: cnt frozen; no events until release.
  - Release from HELD, REPEAT or LATCHED: release_pulse[i] next cycle; state -> IDLE; cnt <= 0.
- Release coinciding with a threshold: release wins; no long or repeat pulse for that cycle.
- At most one of press/release/long/repeat is high per key per cycle.
- Keys are fully independent; simultaneous events on different keys all appear on the pulse vectors.
- Encoded bus:
  - Registered one cycle after the pulse vectors: evt_valid/evt_key/evt_type reflect the pulses of the previous cycle.
  - Priority: key 0 > key 1 > key 2.
  - evt_drop is asserted with evt_valid when any other key also had an event in that source cycle. Dropped events are not queued.
- Key held when reset releases: kv_d = 1 and key_value = 0 produce a press on the first edge after reset. This is intended, since the debouncer holds 3'b111 during its own reset.
- Reset mid-hold: FSM returns to IDLE immediately; no release pulse is generated.
- Counter never exceeds its threshold-1; no wrap.

Test Plan:
Bench overrides: LONG_CYCLES=20, REPEAT_CYCLES=5.
- Short press: key_value 111 -> 110 for 8 cycles -> 111 -> press_pulse=001 one cycle after the falling edge; release_pulse=001 one cycle after the rise; no long pulse; evt sequence: (key0, press) then (key0, release), each one cycle after its pulse.
- Long + repeat, REPEAT_EN=1: hold key1 (101) for 40 cycles -> long_pulse=010 exactly 20 cycles after press_pulse; repeat_pulse at +5, +10, +15 after long; then release_pulse; evt_type sequence 00, 10, 11, 11, 11, 01.
- REPEAT_EN=0: hold key2 for 40 cycles -> one long_pulse at +20; no repeat pulses; release_pulse on release.
- Boundary: release key0 on the exact cycle its cnt reaches 19 -> release_pulse only; long_pulse never asserted.
- Simultaneous: key_value 111 -> 000 in one cycle -> press_pulse=111; evt_key=0, evt_type=00, evt_drop=1 for one cycle; no events for keys 1 and 2 on the bus.
- Reset mid-hold: key0 held 10 cycles, then assert rst_n=0 -> all outputs 0 asynchronously; after rst_n=1 with key still low, press_pulse=001 on the first edge.

Source files
------------

// File: rtl/key_event_decoder_if.sv
// -----------------------------------------------------------------------------
// key_event_decoder_if
// Purpose : Groups the key-level input and all event outputs of the key event
//           decoder into one bundle.
// Signals :
//   key_value     [2:0] debounced key levels, 0 = pressed, idle 3'b111
//   press_pulse   [2:0] one-cycle pulse per key on press
//   release_pulse [2:0] one-cycle pulse per key on release
//   long_pulse    [2:0] one-cycle pulse per key on long-press threshold
//   repeat_pulse  [2:0] one-cycle pulse per key on each auto-repeat
//   evt_valid           encoded event strobe
//   evt_key       [1:0] key index of encoded event
//   evt_type      [1:0] 00 press, 01 release, 10 long, 11 repeat
//   evt_drop            a lower-priority event was lost this cycle
// Modports: master = key source / event consumer, slave = decoder.
// -----------------------------------------------------------------------------
interface key_event_decoder_if;
    logic [2:0] key_value;
    logic [2:0] press_pulse;
    logic [2:0] release_pulse;
    logic [2:0] long_pulse;
    logic [2:0] repeat_pulse;
    logic       evt_valid;
    logic [1:0] evt_key;
    logic [1:0] evt_type;
    logic       evt_drop;

    modport master (
        output key_value,
        input  press_pulse, release_pulse, long_pulse, repeat_pulse,
        input  evt_valid, evt_key, evt_type, evt_drop
    );

    modport slave (
        input  key_value,
        output press_pulse, release_pulse, long_pulse, repeat_pulse,
        output evt_valid, evt_key, evt_type, evt_drop
    );
endinterface

// File: rtl/key_event_decoder.sv
// -----------------------------------------------------------------------------
// key_event_decoder
// Purpose : Turns three debounced active-low key levels into single-cycle
//           press / release / long-press / auto-repeat events, as per-key pulse
//           vectors and as one priority-encoded event bus (key 0 highest).
// Ports   :
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   kbus   key_event_decoder_if.slave (key_value in, pulses and evt_* out)
// Parameters:
//   LONG_CYCLES   press-to-long-press distance in cycles (>= 2)
//   REPEAT_CYCLES distance between auto-repeat events (>= 2)
//   REPEAT_EN     1 = repeat after long-press, 0 = latch until release
//   CNT_W         hold counter width, holds max(LONG,REPEAT)-1
// -----------------------------------------------------------------------------
module key_event_decoder #(
    parameter int unsigned LONG_CYCLES   = 25_000_000,
    parameter int unsigned REPEAT_CYCLES = 5_000_000,
    parameter bit          REPEAT_EN     = 1'b1,
    parameter int unsigned CNT_W         = 25
) (
    input  logic                 clk,
    input  logic                 rst_n,
    key_event_decoder_if.slave   kbus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HELD    = 2'd1,
        S_REPEAT  = 2'd2,
        S_LATCHED = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LONG_M1   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_M1 = CNT_W'(REPEAT_CYCLES - 1);

    state_t           r_state [3];
    logic [CNT_W-1:0] r_cnt   [3];
    logic [2:0]       r_kv_d;
    logic [2:0]       r_press;
    logic [2:0]       r_release;
    logic [2:0]       r_long;
    logic [2:0]       r_repeat;
    logic             r_evt_valid;
    logic [1:0]       r_evt_key;
    logic [1:0]       r_evt_type;
    logic             r_evt_drop;

    logic [2:0]       w_press;
    logic [2:0]       w_rel;
    logic [2:0]       w_any;
    logic [1:0]       w_sel_key;
    logic [1:0]       w_sel_type;
    logic             w_multi;

    // Only one of the four pulses can be high per key, so a plain
    // priority pick yields the event code.
    function automatic logic [1:0] evt_code(input logic p, input logic r,
                                            input logic l, input logic rp);
        logic [1:0] code;
        code = 2'b00;
        if (r)       code = 2'b01;
        else if (l)  code = 2'b10;
        else if (rp) code = 2'b11;
        else if (p)  code = 2'b00;
        return code;
    endfunction

    assign w_press = r_kv_d & ~kbus.key_value;
    assign w_rel   = ~r_kv_d & kbus.key_value;
    assign w_any   = r_press | r_release | r_long | r_repeat;
    assign w_multi = (w_any[0] & w_any[1]) | (w_any[0] & w_any[2]) |
                     (w_any[1] & w_any[2]);

    // Walk from key 2 down to key 0 so the lowest index overwrites last.
    always_comb begin
        w_sel_key  = 2'd0;
        w_sel_type = 2'd0;
        for (int i = 2; i >= 0; i--) begin
            if (w_any[i]) begin
                w_sel_key  = 2'(i);
                w_sel_type = evt_code(r_press[i], r_release[i], r_long[i], r_repeat[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_kv_d      <= 3'b111;
            r_press     <= 3'b000;
            r_release   <= 3'b000;
            r_long      <= 3'b000;
            r_repeat    <= 3'b000;
            r_evt_valid <= 1'b0;
            r_evt_key   <= 2'd0;
            r_evt_type  <= 2'd0;
            r_evt_drop  <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                r_state[i] <= S_IDLE;
                r_cnt[i]   <= '0;
            end
        end else begin
            r_kv_d <= kbus.key_value;

            // Encoded bus lags the pulse vectors by one cycle.
            r_evt_valid <= |w_any;
            r_evt_key   <= w_sel_key;
            r_evt_type  <= w_sel_type;
            r_evt_drop  <= w_multi;

            for (int i = 0; i < 3; i++) begin
                r_press[i]   <= 1'b0;
                r_release[i] <= 1'b0;
                r_long[i]    <= 1'b0;
                r_repeat[i]  <= 1'b0;

                case (r_state[i])
                    S_IDLE: begin
                        if (w_press[i]) begin
                            r_state[i] <= S_HELD;
                            r_cnt[i]   <= '0;
                            r_press[i] <= 1'b1;
                        end
                    end
                    S_HELD: begin
                        // Release is checked first so it wins over a threshold.
                        if (w_rel[i]) begin
                            r_state[i]   <= S_IDLE;
                            r_cnt[i]     <= '0;
                            r_release[i] <= 1'b1;
                        end else if (r_cnt[i] == LONG_M1) begin
                            r_long[i]  <= 1'b1;
                            r_cnt[i]   <= '0;
                            r_state[i] <= REPEAT_EN ? S_REPEAT : S_LATCHED;
                        end else begin
                            r_cnt[i] <= r_cnt[i] + 1'b1;
                        end
                    end
                    S_REPEAT: begin
                        if (w_rel[i]) begin
                            r_state[i]   <= S_IDLE;
                            r_cnt[i]     <= '0;
                            r_release[i] <= 1'b1;
                        end else if (r_cnt[i] == REPEAT_M1) begin
                            r_repeat[i] <= 1'b1;
                            r_cnt[i]    <= '0;
                        end else begin
                            r_cnt[i] <= r_cnt[i] + 1'b1;
                        end
                    end
                    S_LATCHED: begin
                        if (w_rel[i]) begin
                            r_state[i]   <= S_IDLE;
                            r_cnt[i]     <= '0;
                            r_release[i] <= 1'b1;
                        end
                    end
                    default: begin
                        r_state[i] <= S_IDLE;
                        r_cnt[i]   <= '0;
                    end
                endcase
            end
        end
    end

    assign kbus.press_pulse   = r_press;
    assign kbus.release_pulse = r_release;
    assign kbus.long_pulse    = r_long;
    assign kbus.repeat_pulse  = r_repeat;
    assign kbus.evt_valid     = r_evt_valid;
    assign kbus.evt_key       = r_evt_key;
    assign kbus.evt_type      = r_evt_type;
    assign kbus.evt_drop      = r_evt_drop;

endmodule
